// File: rtl/uart_mult_byte_tx.sv
// Multi-byte 8N1 UART packet transmitter: header, up to _NUM_BYTES payload bytes, optional checksum, tail.
// Define UART_TX_CHKSUM_EN to insert a mod-256 checksum byte (header + payload) before the tail.
module uart_mult_byte_tx #(
  parameter int          CLK_FREQ   = 50_000_000,
  parameter int          UART_BPS   = 115200,
  parameter int          _NUM_BYTES = 12,
  parameter logic [7:0]  _HEAD      = 8'hA5,
  parameter logic [7:0]  _TAIL      = 8'h5A
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      tx_start,
  input  logic [7:0]                tx_len,
  input  logic [8*_NUM_BYTES-1:0]   tx_payload,
  output logic                      uart_txd,
  output logic                      tx_busy,
  output logic                      tx_done,
  output logic [7:0]                tx_byte_cnt
);

  localparam int             BPS_CNT   = CLK_FREQ / UART_BPS;
  localparam int             CW        = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BPS_CNT - 1);
  localparam logic [7:0]     MAX_LEN   = 8'(_NUM_BYTES);
`ifdef UART_TX_CHKSUM_EN
  localparam logic [7:0]     TRAILER   = 8'd2;
`else
  localparam logic [7:0]     TRAILER   = 8'd1;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           baud_q, baud_d;
  logic [2:0]              bit_q, bit_d;
  logic [7:0]              byte_q, byte_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              shift_q, shift_d;
  logic [8*_NUM_BYTES-1:0] pay_q, pay_d;
`ifdef UART_TX_CHKSUM_EN
  logic [7:0]              chk_q, chk_d;
`endif

  logic [7:0] eff_len;
  logic [7:0] cur_byte;
  logic       is_payload;
  logic       baud_wrap;
  logic       last_byte;

  assign eff_len    = (tx_len == 8'd0 || tx_len > MAX_LEN) ? MAX_LEN : tx_len;
  assign baud_wrap  = (baud_q == BAUD_LAST);
  assign is_payload = (byte_q != 8'd0) && (byte_q <= len_q);
  assign last_byte  = (byte_q == (len_q + TRAILER));

  // Payload register shifts down one byte per sent payload byte, so the next one is always in [7:0]
  always_comb begin
    cur_byte = _TAIL;
    if (byte_q == 8'd0)
      cur_byte = _HEAD;
    else if (is_payload)
      cur_byte = pay_q[7:0];
`ifdef UART_TX_CHKSUM_EN
    else if (byte_q == (len_q + 8'd1))
      cur_byte = chk_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    len_d   = len_q;
    shift_d = shift_q;
    pay_d   = pay_q;
`ifdef UART_TX_CHKSUM_EN
    chk_d   = chk_q;
`endif
    if (state_q != IDLE && state_q != DONE)
      baud_d = baud_wrap ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        baud_d  = '0;
        if (tx_start) begin
          state_d = START;
          bit_d   = 3'd0;
          byte_d  = 8'd0;
          len_d   = eff_len;
          pay_d   = tx_payload;
`ifdef UART_TX_CHKSUM_EN
          chk_d   = _HEAD;
`endif
        end
      end
      START: begin
        if (baud_wrap) begin
          state_d = DATA;
          bit_d   = 3'd0;
          shift_d = cur_byte;
          if (is_payload) begin
            pay_d = pay_q >> 8;
`ifdef UART_TX_CHKSUM_EN
            chk_d = chk_q + cur_byte;
`endif
          end
        end
      end
      DATA: begin
        if (baud_wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7)
            state_d = STOP;
          else
            bit_d = bit_q + 3'd1;
        end
      end
      STOP: begin
        // Next start bit follows the last stop cycle with no idle gap
        if (baud_wrap) begin
          if (last_byte) begin
            state_d = DONE;
          end else begin
            state_d = START;
            byte_d  = byte_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 8'd0;
      len_q   <= 8'd0;
      shift_q <= 8'd0;
      pay_q   <= '0;
`ifdef UART_TX_CHKSUM_EN
      chk_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      pay_q   <= pay_d;
`ifdef UART_TX_CHKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign uart_txd    = (state_q == START) ? 1'b0 :
                       (state_q == DATA)  ? shift_q[0] : 1'b1;
  assign tx_busy     = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign tx_done     = (state_q == DONE);
  assign tx_byte_cnt = byte_q;

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Self-checking bench for uart_mult_byte_tx: a serial decoder pops expected bytes and done latencies
// from scoreboard queues filled when each packet is requested.
`timescale 1ns/1ps
module tb_uart_mult_byte_tx;

  localparam int         CLK_FREQ = 1_000_000;
  localparam int         UART_BPS = 100_000;
  localparam int         BPS      = CLK_FREQ / UART_BPS;
  localparam int         NB       = 12;
  localparam logic [7:0] HEAD     = 8'hA5;
  localparam logic [7:0] TAIL     = 8'h5A;
`ifdef UART_TX_CHKSUM_EN
  localparam int         EXTRA    = 3;
`else
  localparam int         EXTRA    = 2;
`endif

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              tx_start;
  logic [7:0]        tx_len;
  logic [8*NB-1:0]   tx_payload;
  logic              uart_txd;
  logic              tx_busy;
  logic              tx_done;
  logic [7:0]        tx_byte_cnt;

  uart_mult_byte_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .UART_BPS   (UART_BPS),
    ._NUM_BYTES (NB),
    ._HEAD      (HEAD),
    ._TAIL      (TAIL)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .tx_start    (tx_start),
    .tx_len      (tx_len),
    .tx_payload  (tx_payload),
    .uart_txd    (uart_txd),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_byte_cnt (tx_byte_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [7:0] byteQ[$];
  int         acceptQ[$];
  int         nBytesQ[$];
  int         checkCount = 0;
  int         passCount  = 0;
  int         doneCount  = 0;
  int         maxByteCnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, observed, expected, cyc);
  endtask

  // Serial decoder: every one of the 10 samples of a bit must agree, so a bit of the wrong width shows up
  bit         inFrame = 0;
  int         sampleIdx;
  logic [9:0] frameBits;
  bit         bitBad;
  int         acceptAt;
  int         nBytes;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      inFrame = 0;
    end else begin
      if (int'(tx_byte_cnt) > maxByteCnt) maxByteCnt = int'(tx_byte_cnt);
      if (!inFrame && uart_txd === 1'b0) begin
        inFrame   = 1;
        sampleIdx = 0;
        bitBad    = 0;
        frameBits = '0;
      end
      if (inFrame) begin
        if (sampleIdx % BPS == 0)
          frameBits[sampleIdx / BPS] = uart_txd;
        else if (uart_txd !== frameBits[sampleIdx / BPS])
          bitBad = 1;
        sampleIdx++;
        if (sampleIdx == 10 * BPS) begin
          inFrame = 0;
          checkOutput("bitTiming", 32'(bitBad), 0);
          checkOutput("stopBit", 32'(frameBits[9]), 1);
          if (byteQ.size() == 0)
            checkOutput("unexpectedByte", byteQ.size(), 1);
          else
            checkOutput("serialByte", 32'(frameBits[8:1]), 32'(byteQ.pop_front()));
        end
      end
      if (tx_done === 1'b1) begin
        doneCount++;
        if (acceptQ.size() == 0) begin
          checkOutput("unexpectedDone", acceptQ.size(), 1);
        end else begin
          acceptAt = acceptQ.pop_front();
          nBytes   = nBytesQ.pop_front();
          checkOutput("doneLatency", cyc - acceptAt + 1, nBytes * 10 * BPS + 1);
        end
        checkOutput("busyInDone", 32'(tx_busy), 0);
        checkOutput("txdInDone", 32'(uart_txd), 1);
      end
    end
  end

  task automatic applyStimulus(input int len, input logic [8*NB-1:0] payload, input bit inDoneCycle);
    int L;
`ifdef UART_TX_CHKSUM_EN
    logic [7:0] sum;
    sum = HEAD;
`endif
    L = (len == 0 || len > NB) ? NB : len;
    byteQ.push_back(HEAD);
    for (int k = 0; k < L; k++) begin
      byteQ.push_back(payload[8*k +: 8]);
`ifdef UART_TX_CHKSUM_EN
      sum = sum + payload[8*k +: 8];
`endif
    end
`ifdef UART_TX_CHKSUM_EN
    byteQ.push_back(sum);
`endif
    byteQ.push_back(TAIL);
    if (!inDoneCycle) @(negedge sys_clk);
    tx_len     = 8'(len);
    tx_payload = payload;
    tx_start   = 1'b1;
    @(posedge sys_clk);
    #1;
    tx_start = 1'b0;
    acceptQ.push_back(cyc);
    nBytesQ.push_back(L + EXTRA);
    checkOutput("busyAfterAccept", 32'(tx_busy), 1);
    checkOutput("startBitNow", 32'(uart_txd), 0);
    checkOutput("byteCntStart", 32'(tx_byte_cnt), 0);
  endtask

  task automatic waitDone(input int limit);
    int startCount;
    startCount = doneCount;
    for (int i = 0; i < limit && doneCount == startCount; i++) begin
      @(negedge sys_clk);
      #1;
    end
    if (doneCount == startCount)
      checkOutput("doneTimeout", doneCount, startCount + 1);
  endtask

  task automatic waitDoneCycle(input int limit, output bit found);
    found = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge sys_clk);
      if (tx_done === 1'b1) begin
        found = 1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [8*NB-1:0] p;
    int  txdHigh, busyLow, doneLow, cntZero, dcBefore;
    bit  found;

    sys_rst_n  = 1'b0;
    tx_start   = 1'b0;
    tx_len     = 8'd0;
    tx_payload = '0;
    #3;
    checkOutput("resetTxd", 32'(uart_txd), 1);
    checkOutput("resetBusy", 32'(tx_busy), 0);
    checkOutput("resetDone", 32'(tx_done), 0);
    checkOutput("resetByteCnt", 32'(tx_byte_cnt), 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Idle line after reset with no requests
    txdHigh = 0; busyLow = 0; doneLow = 0; cntZero = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      txdHigh += (uart_txd === 1'b1) ? 1 : 0;
      busyLow += (tx_busy === 1'b0) ? 1 : 0;
      doneLow += (tx_done === 1'b0) ? 1 : 0;
      cntZero += (tx_byte_cnt === 8'd0) ? 1 : 0;
    end
    checkOutput("idleTxd", txdHigh, 1000);
    checkOutput("idleBusy", busyLow, 1000);
    checkOutput("idleDone", doneLow, 1000);
    checkOutput("idleByteCnt", cntZero, 1000);

    // Two-byte packet 01 02
    p = '0;
    p[7:0]  = 8'h01;
    p[15:8] = 8'h02;
    applyStimulus(2, p, 0);
    waitDone(2000);
    repeat (20) @(negedge sys_clk);
    checkOutput("doneOnce", doneCount, 1);

    // Zero length clamps to a full 12-byte payload
    for (int k = 0; k < NB; k++) p[8*k +: 8] = 8'(k);
    maxByteCnt = 0;
    applyStimulus(0, p, 0);
    waitDone(3000);
    repeat (5) @(negedge sys_clk);
    checkOutput("maxByteCnt", maxByteCnt, NB + EXTRA - 1);

    // Mid-packet request and payload change are ignored; request in DONE starts the next packet
    for (int k = 0; k < NB; k++) p[8*k +: 8] = 8'($urandom);
    applyStimulus(3, p, 0);
    repeat (150) @(negedge sys_clk);
    tx_payload = ~p;
    tx_len     = 8'd5;
    tx_start   = 1'b1;
    @(negedge sys_clk);
    tx_start   = 1'b0;
    waitDoneCycle(1000, found);
    checkOutput("doneSeen", 32'(found), 1);
    if (found) begin
      for (int k = 0; k < NB; k++) p[8*k +: 8] = 8'($urandom);
      applyStimulus(2, p, 1);
      waitDone(1000);
    end
    repeat (5) @(negedge sys_clk);

    // Reset during payload byte 1 aborts the packet
    for (int k = 0; k < NB; k++) p[8*k +: 8] = 8'($urandom);
    applyStimulus(4, p, 0);
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      if (tx_byte_cnt === 8'd2) begin
        found = 1;
        break;
      end
    end
    checkOutput("reachedByte2", 32'(found), 1);
    repeat (35) @(negedge sys_clk);
    #2;
    dcBefore  = doneCount;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("abortTxd", 32'(uart_txd), 1);
    checkOutput("abortBusy", 32'(tx_busy), 0);
    checkOutput("abortDone", 32'(tx_done), 0);
    byteQ.delete();
    acceptQ.delete();
    nBytesQ.delete();
    repeat (3) @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
    repeat (300) @(negedge sys_clk);
    checkOutput("noDoneAfterAbort", doneCount, dcBefore);
    checkOutput("idleAfterAbort", 32'(uart_txd), 1);

    for (int k = 0; k < NB; k++) p[8*k +: 8] = 8'($urandom);
    applyStimulus(5, p, 0);
    waitDone(2000);
    repeat (20) @(negedge sys_clk);
    checkOutput("bytesLeft", byteQ.size(), 0);
    checkOutput("donesLeft", acceptQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_mult_byte_tx.md
Name: uart_mult_byte_tx

Overview:
Multi-byte UART packet transmitter on the 50 MHz domain. It is the return path for the multi-byte UART receiver.
- Frames a status/response packet as header, up to _NUM_BYTES payload bytes, optional checksum and tail.
- Serialises the packet 8N1, LSB first, onto uart_txd.
- Driven by the register mapper to report channel busy/valid status back to the host.

Parameters:
CLK_FREQ, 50_000_000, input clock frequency in Hz
UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS, integer-truncated (434 at defaults)
_NUM_BYTES, 12, maximum payload bytes per packet
_HEAD, 8'hA5, header byte
_TAIL, 8'h5A, tail byte

Ports:
sys_clk  input  1  system clock (clk_50M); single clock domain
sys_rst_n  input  1  asynchronous, active-low reset
tx_start  input  1  single-cycle packet request
tx_len  input  8  payload byte count; 0 or >_NUM_BYTES means _NUM_BYTES
tx_payload  input  8*_NUM_BYTES  payload; byte k = tx_payload[8k+7:8k], byte 0 is sent first
uart_txd  output  1  serial line; idle high
tx_busy  output  1  high while a packet is in flight
tx_done  output  1  one-cycle pulse when the packet completes
tx_byte_cnt  output  8  index of the byte currently on the line (0 = header)

Behaviour:
Reset (asynchronous, sys_rst_n low) values:
- uart_txd=1, tx_busy=0, tx_done=0, tx_byte_cnt=0; FSM=IDLE; all counters cleared.
- Reset mid-packet aborts at once; the line returns high, with no partial stop bit and no tx_done.

FSM states: IDLE -> START -> DATA -> STOP -> (START for next byte | DONE) -> IDLE.
- IDLE: tx_start=1 is accepted.
  - Latch tx_payload and the effective length into internal registers in the same edge.
  - tx_busy=1 from the next cycle.
  - The start bit drives uart_txd=0 from the next cycle.
- Bit timing: each bit (start, 8 data, stop) holds exactly BPS_CNT cycles.
  - The baud counter runs 0..BPS_CNT-1 and wraps; the bit index advances on wrap.
- Byte order: _HEAD, payload[0..L-1], checksum (macro only), _TAIL. Byte count = L+2, or L+3 with the checksum.
- tx_byte_cnt increments at the start-bit edge of each new byte.
- The next byte's start bit follows the stop bit's last cycle immediately, with no idle gap.
- DONE (1 cycle): tx_done=1, tx_busy=0, uart_txd=1; then IDLE.
  - Packet latency from the accepting edge to tx_done = (L+2[+1])*10*BPS_CNT + 1 cycles.
- tx_start while tx_busy=1 is ignored; no queueing.
- tx_start in the DONE cycle is accepted; a back-to-back packet starts on the next cycle.
- Payload changes after acceptance do not affect the packet in flight.
- tx_len effective length L:
  - 1.._NUM_BYTES is used as-is.
  - 0 or >_NUM_BYTES clamps to _NUM_BYTES.

Optional Feature:
Macro UART_TX_CHKSUM_EN.
- Defined: a checksum byte is inserted between the last payload byte and _TAIL. The checksum is the 8-bit sum, mod 256, of _HEAD and all L payload bytes.
- Undefined: no checksum byte is sent and its logic is absent; the frame is _HEAD, payload, _TAIL.

Test Plan:
All scenarios use CLK_FREQ=1_000_000 and UART_BPS=100_000 (BPS_CNT=10).
1. Reset, no stimulus -> uart_txd=1, tx_busy=0, tx_done=0, tx_byte_cnt=0 for 1000 cycles.
2. tx_len=2, payload bytes 0x01,0x02, macro off -> bench UART decodes A5 01 02 5A.
   - Each bit is exactly 10 cycles.
   - tx_done pulses once, 401 cycles after the accepting edge.
3. Same as 2 with UART_TX_CHKSUM_EN -> A5 01 02 A8 5A; tx_done at cycle 501.
4. tx_len=0 with a 12-byte incrementing payload 0x00..0x0B -> 14 bytes sent, payload 00..0B in order; tx_byte_cnt reaches 13.
5. tx_start pulsed again mid-packet, then again in the DONE cycle:
   - mid-packet request ignored; first frame unchanged;
   - DONE-cycle request starts a second packet the next cycle; busy low for exactly 1 cycle.
6. sys_rst_n pulsed low during payload byte 1 -> uart_txd=1 immediately, tx_busy=0, no tx_done.
   - A subsequent tx_start produces a clean full packet.
